// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencing controller for an N-stage CIC decimator.
// It flushes the integrators, gates integrator updates, counts input samples
// to pulse the comb chain once every R samples, and handshakes the decimated
// output while tracking overflow and overrun.
// Optional feature macro: CIC_DECIM_CTRL_OVR_CNT_EN adds an 8-bit saturating
// overrun event counter on port ovr_cnt.
module cic_decim_ctrl #(
  parameter int N         = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] ratio,
  input  logic                 in_valid,
  input  logic [N-1:0]         ovf_in,
  input  logic                 out_ready,
  output logic                 int_clr,
  output logic                 int_en,
  output logic                 comb_en,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 ovf_sticky,
  output logic                 ovr_sticky
`ifdef CIC_DECIM_CTRL_OVR_CNT_EN
  ,
  output logic [7:0]           ovr_cnt
`endif
);

  localparam int FW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state_reg, state_next;
  logic [FW-1:0]        flush_cnt_reg, flush_cnt_next;
  logic [CNT_WIDTH-1:0] phase_reg, phase_next;
  logic [CNT_WIDTH-1:0] ratio_reg, ratio_next;
  logic                 comb_reg, comb_next;
  logic                 out_valid_reg, out_valid_next;
  logic                 ovf_reg, ovf_next;
  logic                 ovr_reg, ovr_next;
  logic                 overrun;

  // A comb pulse landing on an unconsumed sample overwrites it.
  assign overrun = comb_reg && out_valid_reg && !out_ready;

  // Next-state and next-value logic for the FSM and its datapath registers.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    phase_next     = phase_reg;
    ratio_next     = ratio_reg;
    comb_next      = 1'b0;
    out_valid_next = comb_reg | (out_valid_reg & ~out_ready);
    ovf_next       = ovf_reg;
    ovr_next       = ovr_reg | overrun;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
          phase_next     = '0;
          ratio_next     = (ratio == '0) ? CNT_WIDTH'(1) : ratio;
          ovf_next       = 1'b0;
          ovr_next       = 1'b0;
        end
      end
      FLUSH: begin
        if (flush_cnt_reg == FW'(N - 1)) begin
          state_next = RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg + FW'(1);
        end
      end
      RUN: begin
        if (|ovf_in) begin
          ovf_next = 1'b1;
        end
        if (in_valid) begin
          if (phase_reg == ratio_reg - CNT_WIDTH'(1)) begin
            phase_next = '0;
            comb_next  = 1'b1;
          end else begin
            phase_next = phase_reg + CNT_WIDTH'(1);
          end
        end
        // The sample taken alongside stop still counts; any partial phase is dropped.
        if (stop) begin
          state_next = DRAIN;
          phase_next = '0;
        end
      end
      DRAIN: begin
        // Wait for a comb pulse issued on the stop cycle to become a sample too.
        if (!out_valid_reg && !comb_reg) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      flush_cnt_reg <= '0;
      phase_reg     <= '0;
      ratio_reg     <= CNT_WIDTH'(1);
      comb_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      phase_reg     <= phase_next;
      ratio_reg     <= ratio_next;
      comb_reg      <= comb_next;
      out_valid_reg <= out_valid_next;
      ovf_reg       <= ovf_next;
      ovr_reg       <= ovr_next;
    end
  end

`ifdef CIC_DECIM_CTRL_OVR_CNT_EN
  logic [7:0] ovr_cnt_reg;

  // Saturating count of overrun events, cleared on each accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovr_cnt_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      ovr_cnt_reg <= '0;
    end else if (overrun && ovr_cnt_reg != 8'hFF) begin
      ovr_cnt_reg <= ovr_cnt_reg + 8'd1;
    end
  end

  assign ovr_cnt = ovr_cnt_reg;
`endif

  assign int_clr    = (state_reg == FLUSH);
  assign int_en     = (state_reg == RUN) && in_valid;
  assign busy       = (state_reg != IDLE);
  assign comb_en    = comb_reg;
  assign out_valid  = out_valid_reg;
  assign ovf_sticky = ovf_reg;
  assign ovr_sticky = ovr_reg;

endmodule
